// File: rtl/arm_mem_pkg.sv
// Shared definitions for the data-memory path: responder FSM states,
// the default SRAM mapping base and the SRAM data width.
package arm_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int unsigned DEFAULT_BASE_ADDR = 1024;
    localparam int unsigned SRAM_DW           = 16;

endpackage

// File: rtl/sram_responder.sv
// Data-memory responder: runs each 32-bit word request as two 16-bit
// accesses on an asynchronous SRAM and signals completion on ready.
module sram_responder
    import arm_mem_pkg::*;
#(
    parameter int unsigned BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int unsigned SRAM_ADDR_W = 18,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_r_en,
    input  logic                   mem_w_en,
    input  logic [31:0]            address,
    input  logic [31:0]            wdata,
    output logic [31:0]            rdata,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [SRAM_DW-1:0]     sram_dq_out,
    input  logic [SRAM_DW-1:0]     sram_dq_in,
    output logic                   sram_dq_oe,
    output logic                   sram_we_n,
    output logic                   sram_oe_n
);

    localparam int unsigned IDX_W = SRAM_ADDR_W - 1;
    localparam logic [3:0]  LAST  = 4'(WAIT_CYCLES - 1);

    state_t             state;
    logic [3:0]         cnt;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   req_idx;
    logic               is_write;
    logic [SRAM_DW-1:0] wdata_hi;
    logic [SRAM_DW-1:0] low_hold;
    logic               phase_end;

    // Out-of-range addresses wrap: the truncation is the whole mapping.
    assign req_idx   = IDX_W'((address - BASE_ADDR) >> 2);
    assign phase_end = (cnt == LAST);
    assign ready     = (state == DONE) || (state == IDLE && !mem_r_en && !mem_w_en);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            is_write    <= 1'b0;
            wdata_hi    <= '0;
            low_hold    <= '0;
            rdata       <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_w_en || mem_r_en) begin
                        state     <= LOW;
                        cnt       <= '0;
                        idx       <= req_idx;
                        is_write  <= mem_w_en;
                        sram_addr <= {req_idx, 1'b0};
                        if (mem_w_en) begin
                            wdata_hi    <= wdata[31:16];
                            sram_dq_out <= wdata[15:0];
                            sram_dq_oe  <= 1'b1;
                            sram_we_n   <= 1'b0;
                        end else begin
                            sram_oe_n <= 1'b0;
                        end
                    end
                end
                LOW: begin
                    if (phase_end) begin
                        state     <= HIGH;
                        cnt       <= '0;
                        sram_addr <= {idx, 1'b1};
                        if (is_write) begin
                            sram_dq_out <= wdata_hi;
                        end else begin
                            low_hold <= sram_dq_in;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                HIGH: begin
                    if (phase_end) begin
                        state      <= DONE;
                        cnt        <= '0;
                        sram_dq_oe <= 1'b0;
                        sram_we_n  <= 1'b1;
                        sram_oe_n  <= 1'b1;
                        if (!is_write) begin
                            rdata <= {sram_dq_in, low_hold};
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_responder.sv
// Randomized bench for sram_responder: a word-level reference model and an
// SRAM pin model, checked every cycle, plus directed literal scenarios.
module tb_sram_responder;

    localparam int unsigned W    = 2;
    localparam int unsigned BASE = 1024;

    logic        clk;
    logic        rst;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;
    logic        sram_oe_n;

    sram_responder #(
        .BASE_ADDR  (BASE),
        .SRAM_ADDR_W(18),
        .WAIT_CYCLES(W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_r_en   (mem_r_en),
        .mem_w_en   (mem_w_en),
        .address    (address),
        .wdata      (wdata),
        .rdata      (rdata),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_in (sram_dq_in),
        .sram_dq_oe (sram_dq_oe),
        .sram_we_n  (sram_we_n),
        .sram_oe_n  (sram_oe_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    // SRAM pin model: half-word array, written while the strobe is low.
    logic [15:0] hw [int];

    function automatic logic [15:0] hw_rd(input int k);
        return hw.exists(k) ? hw[k] : 16'h0000;
    endfunction

    always @(negedge clk) begin
        if (!sram_we_n && sram_dq_oe) hw[int'(sram_addr)] = sram_dq_out;
        sram_dq_in = !sram_oe_n ? hw_rd(int'(sram_addr)) : 16'($urandom);
    end

    // Word-level reference model.
    logic [31:0] ref_word [int];

    function automatic logic [31:0] ref_rd(input int k);
        return ref_word.exists(k) ? ref_word[k] : 32'h0;
    endfunction

    function automatic logic [16:0] idx_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return 17'((off / 4) % (32'd1 << 17));
    endfunction

    bit          m_busy = 1'b0;
    int          m_k;
    bit          m_wr;
    logic [16:0] m_idx;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata = '0;
    logic [17:0] m_last_addr = '0;

    always @(negedge clk) begin : compare
        logic [17:0] ea;
        bit          hi;
        if (!rst) begin
            chk("rst_ready", 32'(ready), 32'(!(mem_r_en || mem_w_en)));
            chk("rst_rdata", rdata, 32'h0);
            chk("rst_we_n", 32'(sram_we_n), 32'd1);
            chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
            chk("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
            chk("rst_addr", 32'(sram_addr), 32'd0);
            m_busy      = 1'b0;
            m_rdata     = '0;
            m_last_addr = '0;
        end else if (!m_busy) begin
            chk("idle_ready", 32'(ready), 32'(!(mem_r_en || mem_w_en)));
            chk("idle_we_n", 32'(sram_we_n), 32'd1);
            chk("idle_oe_n", 32'(sram_oe_n), 32'd1);
            chk("idle_dq_oe", 32'(sram_dq_oe), 32'd0);
            chk("idle_addr", 32'(sram_addr), 32'(m_last_addr));
            chk("idle_rdata", rdata, m_rdata);
            if (mem_w_en || mem_r_en) begin
                m_busy  = 1'b1;
                m_k     = 0;
                m_wr    = mem_w_en;
                m_idx   = idx_of(address);
                m_wdata = wdata;
            end
        end else begin
            m_k++;
            if (m_k <= 2 * W) begin
                hi = (m_k > W);
                ea = {m_idx, hi};
                chk("act_ready", 32'(ready), 32'd0);
                chk("act_addr", 32'(sram_addr), 32'(ea));
                chk("act_we_n", 32'(sram_we_n), 32'(!m_wr));
                chk("act_oe_n", 32'(sram_oe_n), 32'(m_wr));
                chk("act_dq_oe", 32'(sram_dq_oe), 32'(m_wr));
                if (m_wr) chk("act_dq_out", 32'(sram_dq_out), hi ? 32'(m_wdata[31:16]) : 32'(m_wdata[15:0]));
                chk("act_rdata", rdata, m_rdata);
                m_last_addr = ea;
            end else begin
                if (m_wr) ref_word[int'(m_idx)] = m_wdata;
                else      m_rdata = ref_rd(int'(m_idx));
                chk("done_ready", 32'(ready), 32'd1);
                chk("done_we_n", 32'(sram_we_n), 32'd1);
                chk("done_oe_n", 32'(sram_oe_n), 32'd1);
                chk("done_dq_oe", 32'(sram_dq_oe), 32'd0);
                chk("done_addr", 32'(sram_addr), 32'(m_last_addr));
                chk("done_rdata", rdata, m_rdata);
                m_busy = 1'b0;
            end
        end
    end

    // Presents a request and holds it until ready is seen high (DONE);
    // returns the cycle count from the IDLE cycle through DONE.
    task automatic do_req(input bit w, input bit r, input logic [31:0] a,
                          input logic [31:0] d, output int cyc);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        mem_w_en = w; mem_r_en = r; address = a; wdata = d;
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cyc++;
            if (ready) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
            address = $urandom;
            wdata   = $urandom;
        end
        if (!got) chk("req_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        mem_w_en = 1'b0; mem_r_en = 1'b0;
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic preload(input int k, input logic [31:0] v);
        hw[2 * k]     = v[15:0];
        hw[2 * k + 1] = v[31:16];
        ref_word[k]   = v;
    endtask

    initial begin : stim
        int          c;
        int          c1;
        int          sel;
        bit          w;
        bit          r;
        logic [31:0] a;

        rst = 1'b0;
        mem_r_en = 1'b0; mem_w_en = 1'b0; address = '0; wdata = '0;
        for (int i = 0; i < 16; i++) preload(i, $urandom);
        preload(32'h1FFFF, $urandom);
        preload(32'h1FFFE, $urandom);
        hw[2] = 16'h5678;
        hw[3] = 16'h1234;
        ref_word[1] = 32'h1234_5678;

        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_we_n", 32'(sram_we_n), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        idle(1);

        do_req(1'b0, 1'b1, 32'd1028, 32'h0, c);
        chk("rd_cycles", 32'(c), 32'd6);
        chk("rd_data", rdata, 32'h1234_5678);

        do_req(1'b1, 1'b0, 32'd1028, 32'hDEAD_BEEF, c);
        chk("wr_cycles", 32'(c), 32'd6);
        chk("wr_lo_hw", 32'(hw_rd(2)), 32'h0000_BEEF);
        chk("wr_hi_hw", 32'(hw_rd(3)), 32'h0000_DEAD);
        idle(2);

        do_req(1'b1, 1'b1, 32'd1032, 32'hCAFE_F00D, c);
        chk("both_rdata_kept", rdata, 32'h1234_5678);
        chk("both_lo_hw", 32'(hw_rd(4)), 32'h0000_F00D);
        chk("both_hi_hw", 32'(hw_rd(5)), 32'h0000_CAFE);
        idle(1);

        do_req(1'b1, 1'b0, 32'd1040, 32'h0123_4567, c1);
        do_req(1'b0, 1'b1, 32'd1040, 32'h0, c);
        chk("b2b_cycles", 32'(c1 + c), 32'd12);
        chk("b2b_rdata", rdata, 32'h0123_4567);
        idle(1);

        // Abandon a write during its HIGH phase with an asynchronous reset.
        @(posedge clk); #1;
        mem_w_en = 1'b1; address = 32'd1044; wdata = 32'h0BAD_F00D;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_we_active", 32'(sram_we_n), 32'd0);
        #1;
        rst = 1'b0; mem_w_en = 1'b0;
        #1;
        chk("async_we_n", 32'(sram_we_n), 32'd1);
        chk("async_dq_oe", 32'(sram_dq_oe), 32'd0);
        chk("async_oe_n", 32'(sram_oe_n), 32'd1);
        chk("async_ready", 32'(ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(ready), 32'd1);
        chk("post_rst_we_n", 32'(sram_we_n), 32'd1);

        do_req(1'b0, 1'b1, 32'd1028, 32'h0, c);
        chk("post_rst_rd_cycles", 32'(c), 32'd6);
        chk("post_rst_rd_data", rdata, 32'hDEAD_BEEF);
        do_req(1'b1, 1'b0, 32'd1044, 32'h0BAD_F00D, c);
        do_req(1'b0, 1'b1, 32'd1047, 32'h0, c);
        chk("reissue_rdata", rdata, 32'h0BAD_F00D);

        do_req(1'b1, 1'b0, 32'd1020, 32'h5A5A_A5A5, c);
        chk("wrap_lo_hw", 32'(hw_rd(32'h3FFFE)), 32'h0000_A5A5);
        do_req(1'b0, 1'b1, 32'd1020, 32'h0, c);
        chk("wrap_rdata", rdata, 32'h5A5A_A5A5);
        idle(1);

        for (int t = 0; t < 80; t++) begin
            sel = int'($urandom_range(0, 9));
            w = (sel < 4) || (sel == 9);
            r = (sel >= 4);
            if (sel % 5 == 0) a = BASE - 4 * $urandom_range(1, 2);
            else              a = BASE + 4 * $urandom_range(0, 15);
            a = a + $urandom_range(0, 3);
            do_req(w, r, a, $urandom, c);
            chk("rand_cycles", 32'(c), 32'd6);
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_responder.md
# sram_responder

Responder for the data-memory request interface driven by the MEM stage. It accepts one 32-bit word read or write per transaction and executes it as two 16-bit half-word accesses on an external asynchronous SRAM. It returns read data and a `ready` signal. The pipeline top freezes its stage registers while `ready` is low. The block sits between the MEM stage and the SRAM pins and replaces the single-cycle data memory.

## Interface
Parameters:
- `BASE_ADDR`, default 1024: byte address that maps to SRAM word 0.
- `SRAM_ADDR_W`, default 18: SRAM half-word address width.
- `WAIT_CYCLES`, default 2: clock cycles per half-word access. Legal values are 1 to 15.

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst`  in  1  — reset, asynchronous, active-low.
- `mem_r_en`  in  1  — read request, held until `ready` is seen high.
- `mem_w_en`  in  1  — write request, held until `ready` is seen high.
- `address`  in  32  — byte address (the MEM stage `alu_res`).
- `wdata`  in  32  — write data (the MEM stage `val_rm`).
- `rdata`  out  32  — read data, registered.
- `ready`  out  1  — transaction complete, or no transaction pending.
- `sram_addr`  out  SRAM_ADDR_W  — half-word address.
- `sram_dq_out`  out  16  — write data to the pad.
- `sram_dq_in`  in  16  — read data from the pad.
- `sram_dq_oe`  out  1  — pad output enable; high only during write phases.
- `sram_we_n`  out  1  — SRAM write strobe, active-low.
- `sram_oe_n`  out  1  — SRAM output enable, active-low.

## Operation
States: IDLE, LOW, HIGH, DONE.

IDLE:
- If `mem_w_en`: latch `address` and `wdata`, mark the transaction as a write, go to LOW.
- Else if `mem_r_en`: latch `address`, mark the transaction as a read, go to LOW.
- If both are high, the request is a write only. `rdata` is unchanged.

Address mapping:
- Word index = (`address` − `BASE_ADDR`) >> 2, computed in 32-bit arithmetic and truncated to SRAM_ADDR_W−1 bits.
- No range check. Out-of-range addresses wrap silently.
- `address[1:0]` is ignored.

LOW:
- `sram_addr` = {word index, 1'b0}.
- Write: `sram_dq_out` = wdata[15:0], `sram_dq_oe` = 1, `sram_we_n` = 0.
- Read: `sram_oe_n` = 0; `sram_dq_in` is captured into a low holding register on the last cycle of the phase.
- After WAIT_CYCLES cycles, go to HIGH.

HIGH:
- `sram_addr` = {word index, 1'b1}.
- Write: data is wdata[31:16].
- Read: on the last cycle, `rdata` ← {sram_dq_in, low holding register}.
- After WAIT_CYCLES cycles, go to DONE.

DONE:
- `ready` = 1 for exactly one cycle.
- Go unconditionally to IDLE. The still-asserted request is not re-executed.

Outputs:
- `ready` = 1 in IDLE with no request and in DONE; otherwise 0. It is combinational from state and request.
- Outside active phases: `sram_we_n` = 1, `sram_oe_n` = 1, `sram_dq_oe` = 0, and `sram_addr` holds its last value.

Phase counter: 4 bits, cleared on each phase entry.

## Timing
Reset (`rst` low, asynchronous):
- state = IDLE, `rdata` = 0, holding register = 0, counter = 0.
- `sram_addr` = 0, `sram_dq_out` = 0, `sram_dq_oe` = 0, `sram_we_n` = 1, `sram_oe_n` = 1.
- `ready` = 1, since no request is present during reset.

Latency:
- A request is first seen in IDLE at cycle 0.
- `ready` is low for 2·WAIT_CYCLES+1 cycles and high in cycle 2·WAIT_CYCLES+1 (DONE).
- `rdata` is valid from DONE onward and holds until the next read completes.

Back-to-back requests: a new request presented in the cycle after DONE starts in that IDLE cycle. There is no bubble beyond the IDLE cycle.

Request changes mid-transaction are ignored because address, data and type are latched.

Reset mid-transaction: the transaction is abandoned and strobes are released immediately. A partial write leaves SRAM content undefined for that word; the requester must reissue.

## Structure
- Package `arm_mem_pkg` holds:
  - the state enum (IDLE, LOW, HIGH, DONE);
  - `BASE_ADDR` default 1024;
  - the 16-bit SRAM data width constant.
- The block is a single module with no sub-modules. The phase counter is inline.

## Test plan
All scenarios use WAIT_CYCLES = 2 and BASE_ADDR = 1024.
- **Reset:** hold `rst` low with no request → `ready` = 1, `rdata` = 0, `sram_we_n` = 1, `sram_oe_n` = 1, `sram_dq_oe` = 0. Assert `rst` low mid-cycle → outputs change without a clock edge.
- **Write:** w_en, address 1028, wdata 0xDEADBEEF → `sram_addr` = 2 with dq 0xBEEF for 2 cycles, then `sram_addr` = 3 with dq 0xDEAD for 2 cycles. `ready` is low for 5 cycles, then high for 1 cycle.
- **Read:** SRAM model holds half-word 2 = 0x5678 and half-word 3 = 0x1234; r_en at address 1028 → `rdata` = 0x12345678 in DONE, cycle 5. `sram_dq_oe` stays 0 throughout.
- **Both enables:** r_en and w_en high together with wdata 0xCAFEF00D → only a write occurs, and `rdata` keeps its prior value.
- **Reset mid-transaction:** drop `rst` during HIGH of a write → next cycle the state is IDLE and `sram_we_n` = 1. After release, a new read completes in 5 cycles.
- **Back-to-back:** write then read issued consecutively, with each request held through its DONE → no re-execution in DONE. The read's IDLE cycle directly follows the write's DONE, and the total is 12 cycles.
